// File: rtl/instr_fetch_pkg.sv
// Shared Y86-64 fetch definitions: icodes, length classes, FSM states, decode payload.
package instr_fetch_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned CONST_BYTES = 8;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [1:0] {
    LC_1B,
    LC_2B,
    LC_9B,
    LC_10B
  } len_class_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BYTE0,
    S_REGS,
    S_CONST,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       need_regids;
    logic       need_valc;
    logic       valid;
    logic [3:0] len;
  } len_info_t;

  // Instruction length in bytes for a length class.
  function automatic logic [3:0] class_len(input len_class_e cls);
    logic [3:0] len;
    len = 4'd1;
    case (cls)
      LC_1B:  len = 4'd1;
      LC_2B:  len = 4'd2;
      LC_9B:  len = 4'd9;
      LC_10B: len = 4'd10;
      default: len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Byte-wide instruction memory port with req/ack handshake.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);

endinterface

// File: rtl/instr_fetch_len_decode.sv
// Combinational length-class lookup from icode.
module instr_fetch_len_decode
  import instr_fetch_pkg::*;
(
  input  logic [3:0] i_icode,
  output len_info_t  o_info_c
);

  len_class_e w_cls;
  logic       w_valid;

  // Map icode to its length class; undefined icodes are flagged invalid.
  always_comb begin
    w_cls   = LC_1B;
    w_valid = 1'b1;
    case (i_icode)
      IHALT, INOP, IRET:              w_cls = LC_1B;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:   w_cls = LC_2B;
      IJXX, ICALL:                    w_cls = LC_9B;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:      w_cls = LC_10B;
      default:                        w_valid = 1'b0;
    endcase
    o_info_c.valid       = w_valid;
    o_info_c.need_regids = (w_cls == LC_2B) || (w_cls == LC_10B);
    o_info_c.need_valc   = (w_cls == LC_9B) || (w_cls == LC_10B);
    o_info_c.len         = class_len(w_cls);
  end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle Y86-64 fetch: pulls instruction bytes over a req/ack port and decodes fields.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned MEM_SIZE = 1024
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [ADDR_W-1:0] valC,
  output logic [ADDR_W-1:0] valP,
  output logic              instr_invalid,
  output logic              imem_error,
  instr_fetch_if.master     imem
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONST_BYTES - 1);

  state_e            r_state, w_state_n;
  logic [ADDR_W-1:0] r_pc, w_pc_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic              r_req, w_req_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;
  logic [3:0]        r_icode, w_icode_n;
  logic [3:0]        r_ifun, w_ifun_n;
  logic [3:0]        r_ra, w_ra_n;
  logic [3:0]        r_rb, w_rb_n;
  logic [ADDR_W-1:0] r_valc, w_valc_n;
  logic [ADDR_W-1:0] r_valp, w_valp_n;
  logic              r_invalid, w_invalid_n;
  logic              r_imem_err, w_imem_err_n;
  logic              r_need_valc, w_need_valc_n;

  logic [BYTE_W-1:0] w_rdata;
  logic              w_ack;
  logic              w_adv;
  logic [ADDR_W-1:0] w_adv_addr;
  logic              w_adv_oor;
  logic              w_pc_oor;
  len_info_t         w_info;

  assign w_rdata    = imem.mem_rdata;
  assign w_ack      = imem.mem_ack & r_req;
  assign w_adv_addr = r_pc + ADDR_W'(r_idx) + ADDR_W'(1);
  assign w_adv_oor  = w_adv_addr >= ADDR_W'(MEM_SIZE);
  assign w_pc_oor   = pc >= ADDR_W'(MEM_SIZE);

  instr_fetch_len_decode u_len_decode (
    .i_icode  (w_rdata[7:4]),
    .o_info_c (w_info)
  );

  // Next-state and next-register values for the fetch sequencer.
  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_idx_n       = r_idx;
    w_cnt_n       = r_cnt;
    w_req_n       = r_req;
    w_addr_n      = r_addr;
    w_icode_n     = r_icode;
    w_ifun_n      = r_ifun;
    w_ra_n        = r_ra;
    w_rb_n        = r_rb;
    w_valc_n      = r_valc;
    w_valp_n      = r_valp;
    w_invalid_n   = r_invalid;
    w_imem_err_n  = r_imem_err;
    w_need_valc_n = r_need_valc;
    w_adv         = 1'b0;

    case (r_state)
      S_BYTE0: begin
        if (w_ack) begin
          w_icode_n = w_rdata[7:4];
          w_ifun_n  = w_rdata[3:0];
          if (!w_info.valid) begin
            w_invalid_n = 1'b1;
            w_valp_n    = r_pc + ADDR_W'(1);
            w_req_n     = 1'b0;
            w_state_n   = S_DONE;
          end else begin
            w_valp_n      = r_pc + ADDR_W'(w_info.len);
            w_need_valc_n = w_info.need_valc;
            if (w_info.len == 4'd1) begin
              w_req_n   = 1'b0;
              w_state_n = S_DONE;
            end else begin
              w_adv     = 1'b1;
              w_state_n = w_info.need_regids ? S_REGS : S_CONST;
            end
          end
        end
      end
      S_REGS: begin
        if (w_ack) begin
          w_ra_n = w_rdata[7:4];
          w_rb_n = w_rdata[3:0];
          if (r_need_valc) begin
            w_adv     = 1'b1;
            w_state_n = S_CONST;
          end else begin
            w_req_n   = 1'b0;
            w_state_n = S_DONE;
          end
        end
      end
      S_CONST: begin
        if (w_ack) begin
          w_valc_n[{r_cnt, 3'b000} +: BYTE_W] = w_rdata;
          if (r_cnt == CNT_LAST) begin
            w_req_n   = 1'b0;
            w_state_n = S_DONE;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
            w_adv   = 1'b1;
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    // Move to the next byte, or abort to DONE when it lies outside memory.
    if (w_adv) begin
      if (w_adv_oor) begin
        w_req_n      = 1'b0;
        w_imem_err_n = 1'b1;
        w_state_n    = S_DONE;
      end else begin
        w_idx_n  = r_idx + IDX_W'(1);
        w_addr_n = w_adv_addr;
      end
    end

    // Accept a new fetch when idle or in the final DONE cycle.
    if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
      w_pc_n        = pc;
      w_idx_n       = '0;
      w_cnt_n       = '0;
      w_icode_n     = IHALT;
      w_ifun_n      = 4'h0;
      w_ra_n        = RNONE;
      w_rb_n        = RNONE;
      w_valc_n      = '0;
      w_valp_n      = pc + ADDR_W'(1);
      w_invalid_n   = 1'b0;
      w_need_valc_n = 1'b0;
      if (w_pc_oor) begin
        w_req_n      = 1'b0;
        w_imem_err_n = 1'b1;
        w_state_n    = S_DONE;
      end else begin
        w_req_n      = 1'b1;
        w_addr_n     = pc;
        w_imem_err_n = 1'b0;
        w_state_n    = S_BYTE0;
      end
    end

    w_busy_n = (w_state_n == S_BYTE0) || (w_state_n == S_REGS) || (w_state_n == S_CONST);
    w_done_n = (w_state_n == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_icode     <= IHALT;
      r_ifun      <= 4'h0;
      r_ra        <= RNONE;
      r_rb        <= RNONE;
      r_valc      <= '0;
      r_valp      <= '0;
      r_invalid   <= 1'b0;
      r_imem_err  <= 1'b0;
      r_need_valc <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_idx       <= w_idx_n;
      r_cnt       <= w_cnt_n;
      r_req       <= w_req_n;
      r_addr      <= w_addr_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_icode     <= w_icode_n;
      r_ifun      <= w_ifun_n;
      r_ra        <= w_ra_n;
      r_rb        <= w_rb_n;
      r_valc      <= w_valc_n;
      r_valp      <= w_valp_n;
      r_invalid   <= w_invalid_n;
      r_imem_err  <= w_imem_err_n;
      r_need_valc <= w_need_valc_n;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign icode         = r_icode;
  assign ifun          = r_ifun;
  assign rA            = r_ra;
  assign rB            = r_rb;
  assign valC          = r_valc;
  assign valP          = r_valp;
  assign instr_invalid = r_invalid;
  assign imem_error    = r_imem_err;
  assign imem.mem_req  = r_req;
  assign imem.mem_addr = r_addr;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed cases plus randomized fetches with wait states.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] pc_i = '0;
  logic        busy, done, inv, ierr;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(64)) mem_bus ();

  instr_fetch #(.ADDR_W(64), .MEM_SIZE(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pc            (pc_i),
    .busy          (busy),
    .done          (done),
    .icode         (icode),
    .ifun          (ifun),
    .rA            (ra),
    .rB            (rb),
    .valC          (valc),
    .valP          (valp),
    .instr_invalid (inv),
    .imem_error    (ierr),
    .imem          (mem_bus)
  );

  // Instruction memory with a programmable number of wait cycles per byte.
  logic [7:0] mem [0:1023];
  int  wait_cfg = 0;
  int  wcnt;
  bit  spur = 1'b0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (mem_bus.mem_req && mem_bus.mem_ack) wcnt <= 0;
    else if (mem_bus.mem_req) wcnt <= wcnt + 1;
  end

  assign mem_bus.mem_ack   = (mem_bus.mem_req && (wcnt >= wait_cfg)) || spur;
  assign mem_bus.mem_rdata = (mem_bus.mem_addr < 64'd1024) ? mem[mem_bus.mem_addr[9:0]] : 8'h00;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    bit          inv, err;
    int          acks, lat, s;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:             return 1;
      4'h2, 4'h6, 4'hA, 4'hB:       return 2;
      4'h7, 4'h8:                   return 9;
      4'h3, 4'h4, 4'h5:             return 10;
      default:                      return 0;
    endcase
  endfunction

  // Reference: walk the instruction's byte list, stopping at the memory edge.
  function automatic exp_t model(input logic [63:0] p, input int w);
    exp_t e;
    int L, j;
    logic [63:0] a;
    logic [7:0] b;
    e.pc = p; e.icode = 4'h0; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
    e.valc = '0; e.valp = '0; e.inv = 1'b0; e.err = 1'b0; e.acks = 0; e.s = 0;
    if (p >= 64'd1024) begin
      e.err  = 1'b1;
      e.valp = p + 64'd1;
    end else begin
      b = mem[p[9:0]];
      e.icode = b[7:4];
      e.ifun  = b[3:0];
      e.acks  = 1;
      L = len_of(e.icode);
      if (L == 0) begin
        e.inv  = 1'b1;
        e.valp = p + 64'd1;
      end else begin
        e.valp = p + 64'(L);
        for (int k = 1; k < L; k++) begin
          a = p + 64'(k);
          if (a >= 64'd1024) begin
            e.err = 1'b1;
            break;
          end
          e.acks++;
          b = mem[a[9:0]];
          if ((L == 2 || L == 10) && k == 1) begin
            e.ra = b[7:4];
            e.rb = b[3:0];
          end else begin
            j = k - ((L == 10) ? 2 : 1);
            e.valc[8*j +: 8] = b;
          end
        end
      end
    end
    e.lat = e.acks * (w + 1) + 1;
    return e;
  endfunction

  // Monitor: checks request addresses and pops the scoreboard on every done pulse.
  initial begin
    int          ack_cnt;
    bit          pend;
    logic [63:0] pend_addr;
    exp_t        e;
    ack_cnt = 0;
    pend = 1'b0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_cnt = 0;
        pend = 1'b0;
      end else begin
        if (pend && mem_bus.mem_req) chk("addr_stable", mem_bus.mem_addr, pend_addr);
        if (mem_bus.mem_req && mem_bus.mem_ack) begin
          if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL req_no_txn: got request at %h, expected none", mem_bus.mem_addr);
          end else begin
            chk("ack_addr", mem_bus.mem_addr, q[0].pc + 64'(ack_cnt));
          end
          ack_cnt++;
        end
        pend = mem_bus.mem_req && !mem_bus.mem_ack;
        pend_addr = mem_bus.mem_addr;
        if (done) begin
          if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL spurious_done: got done=1, expected 0");
          end else begin
            e = q.pop_front();
            chk("icode",   64'(icode), 64'(e.icode));
            chk("ifun",    64'(ifun),  64'(e.ifun));
            chk("rA",      64'(ra),    64'(e.ra));
            chk("rB",      64'(rb),    64'(e.rb));
            chk("valC",    valc,       e.valc);
            chk("valP",    valp,       e.valp);
            chk("invalid", 64'(inv),   64'(e.inv));
            chk("imem_err",64'(ierr),  64'(e.err));
            chk("acks",    64'(ack_cnt), 64'(e.acks));
            chk("latency", 64'(cyc),   64'(e.s + e.lat));
          end
          ack_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one fetch and wait for done; optionally pulse start while busy with a junk pc.
  task automatic do_fetch(input logic [63:0] p, input int w, input bit junk);
    exp_t e;
    int n;
    wait_cfg = w;
    e = model(p, w);
    e.s = cyc;
    q.push_back(e);
    start = 1'b1;
    pc_i  = p;
    step();
    start = 1'b0;
    pc_i  = {$urandom, $urandom};
    n = 0;
    while (!done && n < 500) begin
      if (junk && busy && ($urandom_range(3, 0) == 0)) begin
        start = 1'b1;
        pc_i  = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done for pc %h, expected one within 500 cycles", p);
      q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [63:0] p;
    int sel;
    foreach (mem[i]) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_req",   64'(mem_bus.mem_req), 64'd0);
    chk("rst_addr",  mem_bus.mem_addr, 64'd0);
    chk("rst_icode", 64'(icode), 64'd0);
    chk("rst_ifun",  64'(ifun), 64'd0);
    chk("rst_rA",    64'(ra), 64'hF);
    chk("rst_rB",    64'(rb), 64'hF);
    chk("rst_valC",  valc, 64'd0);
    chk("rst_valP",  valp, 64'd0);
    chk("rst_inv",   64'(inv), 64'd0);
    chk("rst_ierr",  64'(ierr), 64'd0);
    rst = 1'b0;
    step();

    // irmovq with full constant, zero wait
    mem[0] = 8'h30; mem[1] = 8'hF3;
    for (int k = 0; k < 8; k++) mem[2 + k] = 8'(8 - k);
    do_fetch(64'h0, 0, 1'b0);
    step();

    // halt
    mem[32'h20] = 8'h00;
    do_fetch(64'h20, 0, 1'b0);
    step();

    // call with two wait cycles per byte
    mem[32'h40] = 8'h80; mem[32'h41] = 8'h00; mem[32'h42] = 8'h01;
    do_fetch(64'h40, 2, 1'b0);
    step();

    // invalid icode
    mem[32'h10] = 8'hC0;
    do_fetch(64'h10, 0, 1'b0);

    // irmovq running off the end of memory, issued back-to-back in the DONE cycle
    mem[1020] = 8'h30; mem[1021] = 8'hF2; mem[1022] = 8'h11; mem[1023] = 8'h22;
    do_fetch(64'd1020, 1, 1'b1);
    step();

    // ack with no request outstanding must be ignored
    spur = 1'b1;
    step();
    step();
    spur = 1'b0;
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_req",  64'(mem_bus.mem_req), 64'd0);

    // reset in the middle of the constant bytes
    wait_cfg = 0;
    e = model(64'h0, 0);
    e.s = cyc;
    q.push_back(e);
    start = 1'b1;
    pc_i  = 64'h0;
    step();
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_req",  64'(mem_bus.mem_req), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_rA",   64'(ra), 64'hF);
    step();
    rst = 1'b0;
    mem[0] = 8'h10;
    step();
    do_fetch(64'h0, 0, 1'b0);

    // randomized fetches over random memory
    foreach (mem[i]) mem[i] = 8'($urandom);
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(9, 0);
      if (sel <= 6)      p = 64'($urandom_range(1023, 0));
      else if (sel <= 8) p = 64'($urandom_range(1023, 1012));
      else               p = 64'($urandom_range(1031, 1024));
      if ($urandom_range(1, 0) == 0) begin
        repeat ($urandom_range(2, 0)) step();
      end
      do_fetch(p, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    repeat (3) step();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
